// File: rtl/ras_ckpt.sv
// Return address stack with a speculative copy (prediction side) and an architectural copy
// (in-order commit lanes); flush restores spec from arch. Optional counters under RAS_STATS_EN.
module ras_ckpt #(
    parameter int unsigned PLEN        = 32,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned NRET        = 2,
    parameter int unsigned INSTR_BYTES = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           pred_valid_i,
    input  logic                           pred_is_call_i,
    input  logic                           pred_is_ret_i,
    input  logic [PLEN-1:0]                pred_push_addr_i,
    output logic                           top_valid_o,
    output logic [PLEN-1:0]                top_o,
    input  logic [NRET-1:0]                ras_update_valid_i,
    input  logic [NRET-1:0]                ras_update_is_call_i,
    input  logic [NRET-1:0]                ras_update_is_ret_i,
    input  logic [NRET-1:0][PLEN-1:0]      ras_update_pc_i,
    input  logic                           flush_i,
    output logic [$clog2(DEPTH+1)-1:0]     spec_count_o,
    output logic [$clog2(DEPTH+1)-1:0]     arch_count_o
`ifdef RAS_STATS_EN
    ,
    output logic [31:0]                    spec_overflow_cnt_o,
    output logic [31:0]                    spec_underflow_cnt_o
`endif
);

    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned CNTW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [DEPTH-1:0][PLEN-1:0] ent;
        logic [PTRW-1:0]            ptr;
        logic [CNTW-1:0]            cnt;
    } stack_t;

    // Pop (ignored when empty) then push (overwrites oldest when full).
    function automatic stack_t stack_op(input stack_t s, input logic do_pop,
                                        input logic do_push, input logic [PLEN-1:0] addr);
        stack_t r;
        r = s;
        if (do_pop && (r.cnt != '0)) begin
            r.ptr = r.ptr - PTRW'(1);
            r.cnt = r.cnt - CNTW'(1);
        end
        if (do_push) begin
            r.ptr        = r.ptr + PTRW'(1);
            r.ent[r.ptr] = addr;
            if (r.cnt != CNTW'(DEPTH)) begin
                r.cnt = r.cnt + CNTW'(1);
            end
        end
        return r;
    endfunction

    stack_t spec_q, spec_d;
    stack_t arch_q, arch_d;
    logic   pred_act;

    assign pred_act = pred_valid_i & ~flush_i;

    always_comb begin
        arch_d = arch_q;
        for (int i = 0; i < int'(NRET); i++) begin
            if (ras_update_valid_i[i]) begin
                arch_d = stack_op(arch_d, ras_update_is_ret_i[i], ras_update_is_call_i[i],
                                  ras_update_pc_i[i] + PLEN'(INSTR_BYTES));
            end
        end
    end

    // Flush takes arch including this cycle's commits, so restore never lags retirement.
    always_comb begin
        spec_d = spec_q;
        if (flush_i) begin
            spec_d = arch_d;
        end else if (pred_act) begin
            spec_d = stack_op(spec_q, pred_is_ret_i, pred_is_call_i, pred_push_addr_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spec_q <= '0;
            arch_q <= '0;
        end else begin
            spec_q <= spec_d;
            arch_q <= arch_d;
        end
    end

    assign top_valid_o  = (spec_q.cnt != '0);
    assign top_o        = top_valid_o ? spec_q.ent[spec_q.ptr] : '0;
    assign spec_count_o = spec_q.cnt;
    assign arch_count_o = arch_q.cnt;

`ifdef RAS_STATS_EN
    logic [31:0] ovf_q, unf_q;
    logic        ovf_hit, unf_hit;

    // A call paired with a ret pops first, so it never overflows.
    assign ovf_hit = pred_act & pred_is_call_i & ~pred_is_ret_i &
                     (spec_q.cnt == CNTW'(DEPTH));
    assign unf_hit = pred_act & pred_is_ret_i & (spec_q.cnt == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            if (ovf_hit) ovf_q <= ovf_q + 32'd1;
            if (unf_hit) unf_q <= unf_q + 32'd1;
        end
    end

    assign spec_overflow_cnt_o  = ovf_q;
    assign spec_underflow_cnt_o = unf_q;
`endif

endmodule

// File: tb/tb_ras_ckpt.sv
// Bench for ras_ckpt: queue-based stack model, per-cycle compare, directed and random stimulus.
module tb_ras_ckpt;

    localparam int unsigned PLEN  = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned NRET  = 2;
    localparam int unsigned CW    = $clog2(DEPTH+1);

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      pv, pc_call, pc_ret;
    logic [PLEN-1:0]           paddr;
    logic                      top_valid;
    logic [PLEN-1:0]           top;
    logic [NRET-1:0]           uv, uc, ur;
    logic [NRET-1:0][PLEN-1:0] upc;
    logic                      flush;
    logic [CW-1:0]             spec_count, arch_count;
`ifdef RAS_STATS_EN
    logic [31:0]               ovf_cnt, unf_cnt;
`endif

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [PLEN-1:0] m_spec[$];
    logic [PLEN-1:0] m_arch[$];
    int              m_ovf = 0;
    int              m_unf = 0;

    always #5 clk = ~clk;

    ras_ckpt #(.PLEN(PLEN), .DEPTH(DEPTH), .NRET(NRET), .INSTR_BYTES(4)) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .pred_valid_i         (pv),
        .pred_is_call_i       (pc_call),
        .pred_is_ret_i        (pc_ret),
        .pred_push_addr_i     (paddr),
        .top_valid_o          (top_valid),
        .top_o                (top),
        .ras_update_valid_i   (uv),
        .ras_update_is_call_i (uc),
        .ras_update_is_ret_i  (ur),
        .ras_update_pc_i      (upc),
        .flush_i              (flush),
        .spec_count_o         (spec_count),
        .arch_count_o         (arch_count)
`ifdef RAS_STATS_EN
        ,
        .spec_overflow_cnt_o  (ovf_cnt),
        .spec_underflow_cnt_o (unf_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a stack is a bounded queue; back is the top, front is the oldest entry.
    always @(posedge clk) begin
        if (rst) begin
            m_spec.delete();
            m_arch.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            for (int i = 0; i < int'(NRET); i++) begin
                if (uv[i]) begin
                    if (ur[i] && m_arch.size() > 0) void'(m_arch.pop_back());
                    if (uc[i]) begin
                        if (m_arch.size() == DEPTH) void'(m_arch.pop_front());
                        m_arch.push_back(upc[i] + 32'd4);
                    end
                end
            end
            if (flush) begin
                m_spec = m_arch;
            end else if (pv) begin
                if (pc_ret) begin
                    if (m_spec.size() > 0) void'(m_spec.pop_back());
                    else m_unf++;
                end
                if (pc_call) begin
                    if (m_spec.size() == DEPTH) begin
                        void'(m_spec.pop_front());
                        m_ovf++;
                    end
                    m_spec.push_back(paddr);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("top_valid", {31'b0, top_valid}, {31'b0, m_spec.size() != 0});
            chk("top", top, (m_spec.size() != 0) ? m_spec[$] : 32'h0);
            chk("spec_count", 32'(spec_count), m_spec.size());
            chk("arch_count", 32'(arch_count), m_arch.size());
`ifdef RAS_STATS_EN
            chk("ovf_cnt", ovf_cnt, m_ovf);
            chk("unf_cnt", unf_cnt, m_unf);
`endif
        end
    end

    task automatic idle();
        rst = 0; pv = 0; pc_call = 0; pc_ret = 0; paddr = '0; flush = 0;
        uv = '0; uc = '0; ur = '0; upc = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic pred(input logic c, input logic r, input logic [31:0] a);
        pv = 1; pc_call = c; pc_ret = r; paddr = a;
    endtask

    task automatic lane(input int i, input logic v, input logic c, input logic r,
                        input logic [31:0] pc);
        uv[i] = v; uc[i] = c; ur[i] = r; upc[i] = pc;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
    endtask

    initial begin
        idle();
        rst = 1;
        step();
        do_reset();
        chk_en = 1'b1;
        chk("rst top_valid", {31'b0, top_valid}, 32'd0);
        chk("rst top", top, 32'h0);
        chk("rst spec_count", 32'(spec_count), 32'd0);
        chk("rst arch_count", 32'(arch_count), 32'd0);

        // Basic push/pop
        pred(1, 0, 32'h100); step();
        pred(1, 0, 32'h200); step();
        chk("t1 top", top, 32'h200);
        chk("t1 count", 32'(spec_count), 32'd2);
        pred(0, 1, 32'h0); step();
        chk("t1 pop top", top, 32'h100);
        chk("t1 pop count", 32'(spec_count), 32'd1);

        // Overflow wrap and underflow
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            pred(1, 0, 32'(k * 16)); step();
        end
        chk("t2 full count", 32'(spec_count), 32'd8);
        chk("t2 full top", top, 32'h90);
        for (int k = 0; k < 7; k++) begin
            pred(0, 1, 32'h0); step();
        end
        chk("t2 last top", top, 32'h20);
        pred(0, 1, 32'h0); step();
        chk("t2 empty count", 32'(spec_count), 32'd0);
        pred(0, 1, 32'h0); step();
        chk("t2 underflow count", 32'(spec_count), 32'd0);
        chk("t2 underflow valid", {31'b0, top_valid}, 32'd0);

        // Two commit calls then flush
        do_reset();
        lane(0, 1, 1, 0, 32'h1000); lane(1, 1, 1, 0, 32'h2000); step();
        chk("t3 arch_count", 32'(arch_count), 32'd2);
        flush = 1; step();
        chk("t3 flush top", top, 32'h2004);
        chk("t3 flush count", 32'(spec_count), 32'd2);

        // Call then ret in one cycle; ret on empty; non-contiguous lanes; PC wrap
        lane(0, 1, 1, 0, 32'h3000); lane(1, 1, 0, 1, 32'h0); step();
        chk("t4 call+ret arch", 32'(arch_count), 32'd2);
        do_reset();
        lane(0, 1, 0, 1, 32'h0); lane(1, 0, 1, 0, 32'h4000); step();
        chk("t4 ret empty arch", 32'(arch_count), 32'd0);
        lane(0, 0, 1, 0, 32'h5000); lane(1, 1, 1, 0, 32'hFFFF_FFFC); flush = 1; step();
        chk("t4 lane1 only arch", 32'(arch_count), 32'd1);
        chk("t4 pc wrap top", top, 32'h0);

        // Flush drops same-cycle prediction
        do_reset();
        for (int k = 0; k < 3; k++) begin
            pred(1, 0, 32'h700 + 32'(k)); step();
        end
        pred(1, 0, 32'hBEEF); flush = 1; step();
        chk("t5 spec_count", 32'(spec_count), 32'd0);
        chk("t5 top_valid", {31'b0, top_valid}, 32'd0);

        // Call+ret replaces top: on empty and on full
        pred(1, 1, 32'h55); step();
        chk("cr empty count", 32'(spec_count), 32'd1);
        chk("cr empty top", top, 32'h55);
        for (int k = 0; k < 7; k++) begin
            pred(1, 0, 32'h60 + 32'(k)); step();
        end
        pred(1, 1, 32'h77); step();
        chk("cr full count", 32'(spec_count), 32'd8);
        chk("cr full top", top, 32'h77);

        // Stats sequence and mid-sequence reset
        do_reset();
        for (int k = 0; k < 10; k++) begin
            pred(1, 0, 32'h800 + 32'(k)); step();
        end
        for (int k = 0; k < 9; k++) begin
            pred(0, 1, 32'h0); step();
        end
`ifdef RAS_STATS_EN
        chk("t6 ovf", ovf_cnt, 32'd2);
        chk("t6 unf", unf_cnt, 32'd1);
`endif
        chk("t6 count", 32'(spec_count), 32'd0);
        pred(1, 0, 32'h900); step();
        lane(0, 1, 1, 0, 32'h40); step();
        rst = 1; pred(1, 0, 32'h910); lane(0, 1, 1, 0, 32'h80); step();
        chk("t6 rst top", top, 32'h0);
        chk("t6 rst spec", 32'(spec_count), 32'd0);
        chk("t6 rst arch", 32'(arch_count), 32'd0);
`ifdef RAS_STATS_EN
        chk("t6 rst ovf", ovf_cnt, 32'd0);
        chk("t6 rst unf", unf_cnt, 32'd0);
`endif

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            pv      = ($urandom_range(0, 3) != 0);
            pc_call = $urandom_range(0, 1) == 1;
            pc_ret  = $urandom_range(0, 1) == 1;
            paddr   = $urandom;
            for (int i = 0; i < int'(NRET); i++) begin
                lane(i, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 2) == 0, {$urandom_range(0, 255), 2'b00});
            end
            flush = ($urandom_range(0, 24) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            step();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
